led_serial_rx: RTL
==================

Name: led_serial_rx

Overview:
- Receive-side model of the LED driver-chip serial interface. It is the far end of the LE/DCLK/SDI/GCLK/scan1..4 link produced by the MiniLED driver.
- Oversamples the link on the 50 MHz system clock and recovers 16-bit grayscale words with their channel and scan indices.
- Flags protocol violations and measures GCLK pulses per scan period.
- Used for on-board loopback checking and as the scoreboard front-end in the driver testbench.

Parameters:
- WORD_W, 16, bits per grayscale word (shift length per LE).
- CH_PER_SCAN, 90, words expected per scan line (360 LEDs / 4 scans).
- SCAN_N, 4, number of scan lines; fixed one-hot width.
- GCNT_W, 16, width of the GCLK pulse counter.

Ports:
- I_clk  in  1  system clock, 50 MHz.
- I_rst_n  in  1  asynchronous active-low reset.
- I_le  in  1  latch enable from the link (asynchronous to I_clk).
- I_dclk  in  1  data clock from the link, at most 12.5 MHz.
- I_sdi  in  1  serial data, MSB first.
- I_gclk  in  1  grayscale PWM clock.
- I_scan  in  SCAN_N  scan1..scan4 as a vector; bit0 = scan1.
- I_clr_err  in  1  clears all sticky error flags.
- O_word_vld  out  1  one-cycle pulse; a word has been accepted.
- O_word  out  WORD_W  recovered word; valid while O_word_vld is high.
- O_ch_idx  out  7  channel index of the word, 0..CH_PER_SCAN-1.
- O_scan_idx  out  2  scan index of the word.
- O_line_done  out  1  pulse together with the last word of a line.
- O_frame_done  out  1  pulse together with the last word of scan SCAN_N-1.
- O_gclk_cnt  out  GCNT_W  GCLK rising edges counted in the previous scan period.
- O_gclk_cnt_vld  out  1  pulse when O_gclk_cnt updates.
- O_err_len  out  1  sticky: LE fell while bit count was not WORD_W.
- O_err_ovf  out  1  sticky: a word arrived after the line was already complete.
- O_err_scan  out  1  sticky: the scan vector was not one-hot.

Behaviour:
- Reset and clocking:
  - One clock, I_clk; reset is asynchronous and active-low on I_rst_n.
  - Every output and internal register resets to 0.
- Input synchronisation:
  - I_le, I_dclk, I_sdi, I_gclk and I_scan each pass through a 2-flop synchroniser, followed by one delay register for edge detection.
  - I_sdi is taken from the same pipeline stage as I_dclk, so the data/clock phase is preserved.
- Link timing requirements:
  - DCLK high and low each last at least 2 I_clk cycles.
  - LE is asserted only while DCLK is low.
- Shifting:
  - On each detected DCLK rising edge: shift_reg <= {shift_reg[WORD_W-2:0], sdi_s}.
  - bit_cnt increments and saturates at WORD_W+1.
  - DCLK edges while LE is high shift normally.
- Latch on LE falling edge:
  - Case bit_cnt == WORD_W and the line is not yet complete: assert O_word_vld for one cycle with O_word = shift_reg, the current O_ch_idx and the current O_scan_idx. Then ch_cnt increments.
  - Case bit_cnt != WORD_W: set O_err_len and produce no O_word_vld.
  - Case the line is already complete (ch_cnt == CH_PER_SCAN): set O_err_ovf and produce no O_word_vld.
  - In every case bit_cnt clears to 0.
- Latency:
  - If the I_clk edge at which the first sync stage first samples LE low is edge N, then O_word_vld is high in the cycle following edge N+3. This latency is fixed at 3 cycles.
- Line and frame completion:
  - O_line_done pulses in the same cycle as the accepted word that has ch_cnt == CH_PER_SCAN-1.
  - O_frame_done additionally pulses in that cycle when the scan index is SCAN_N-1.
- Scan tracking:
  - The synchronised scan vector is compared with its delayed copy.
  - On a change to a one-hot value: scan_idx <= encoded bit, ch_cnt <= 0, O_gclk_cnt <= gclk_cnt, O_gclk_cnt_vld pulses for one cycle, and gclk_cnt is reloaded (0, or 1 if a GCLK rising edge occurs in the same cycle).
  - On a change to a non-one-hot value (zero or multiple bits): set O_err_scan. scan_idx, ch_cnt and gclk_cnt hold.
- GCLK counting:
  - gclk_cnt increments on each GCLK rising edge and saturates at all ones (2^GCNT_W - 1). It does not wrap.
- Simultaneous events:
  - LE fall and scan change in the same cycle: the word is accepted with the old ch/scan indices. The counters then reset, so the next word is channel 0 of the new scan.
- Error flags:
  - I_clr_err clears all sticky flags in the following cycle.
  - If an error condition and I_clr_err occur in the same cycle, the set wins.
- Reset mid-word: the partial shift is discarded. After release, the receiver resynchronises at the next LE falling edge. The first word may raise O_err_len.

Decomposition:
- Package led_rx_pkg holds WORD_W, CH_PER_SCAN, SCAN_N, GCNT_W and the one-hot-to-index function.
- Sub-module led_edge_sync: per-bit 2-flop synchroniser plus rise/fall pulse outputs. It is instantiated for LE, DCLK, GCLK and the scan vector; SDI uses its delayed data output only.

Test Plan:
1. Reset, then DCLK at 12.5 MHz shifting 16 bits 0xA5C3 followed by an LE pulse -> one O_word_vld with O_word=0xA5C3, O_ch_idx=0, O_scan_idx=0, exactly 3 cycles after LE-low sampling.
2. scan=0001; 90 words of value i*7 for i=0..89 -> 90 valid pulses with ch_idx 0..89; O_line_done together with word 89. A 91st word -> O_err_ovf=1 and no vld.
3. Full frame: 4 scans x 90 words, scan stepping 0001→0010→0100→1000 -> O_frame_done once, on word 89 of scan_idx 3; each scan restarts ch_idx at 0.
4. 15 DCLK edges, then LE -> O_err_len=1, no vld; the following 16-bit word is accepted normally. Pulse I_clr_err -> O_err_len=0.
5. 200 GCLK pulses during scan 0, then change to 0010 -> O_gclk_cnt=200 with O_gclk_cnt_vld pulse. Scan vector 0011 -> O_err_scan=1 and scan_idx stays 1.
6. LE fall coincident with a scan change -> word reported with the old indices; the next word has ch_idx=0 and the new scan_idx. Assert I_rst_n mid-shift -> all outputs 0.

Source files
------------

// File: rtl/led_rx_pkg.sv
// Shared constants and helpers for the LED driver-link receiver.
package led_rx_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned CH_PER_SCAN = 90;
  localparam int unsigned SCAN_N      = 4;
  localparam int unsigned GCNT_W      = 16;

  localparam int unsigned CH_W       = 7;
  localparam int unsigned SCAN_IDX_W = 2;
  localparam int unsigned BIT_CNT_W  = $clog2(WORD_W + 2);

  localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(CH_PER_SCAN - 1);
  localparam logic [CH_W-1:0]       CH_FULL   = CH_W'(CH_PER_SCAN);
  localparam logic [BIT_CNT_W-1:0]  BIT_FULL  = BIT_CNT_W'(WORD_W);
  localparam logic [BIT_CNT_W-1:0]  BIT_SAT   = BIT_CNT_W'(WORD_W + 1);
  localparam logic [SCAN_IDX_W-1:0] SCAN_LAST = SCAN_IDX_W'(SCAN_N - 1);

  typedef struct packed {
    logic                  valid;
    logic [SCAN_IDX_W-1:0] idx;
  } scan_dec_t;

  // valid only when exactly one scan line is active
  function automatic scan_dec_t scan_decode(input logic [SCAN_N-1:0] v);
    scan_dec_t   r;
    int unsigned ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < SCAN_N; i++) begin
      if (v[i]) begin
        ones  = ones + 1;
        r.idx = SCAN_IDX_W'(i);
      end
    end
    r.valid = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/led_edge_sync.sv
// Per-bit two-flop synchroniser with a delay stage and registered edge pulses.
module led_edge_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] data_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  logic [Width-1:0] s1_q, s2_q, dly_q, rise_q, fall_q;

  // Edge pulses are registered, so they line up with dly_q (the new level).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      dly_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      dly_q  <= s2_q;
      rise_q <= s2_q & ~dly_q;
      fall_q <= ~s2_q & dly_q;
    end
  end

  assign data_o = dly_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/led_serial_rx.sv
// Receive side of the LE/DCLK/SDI/GCLK/scan link: recovers grayscale words,
// tracks channel/scan position, counts GCLK per scan period and flags errors.
module led_serial_rx
  import led_rx_pkg::*;
(
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_le,
  input  logic                  I_dclk,
  input  logic                  I_sdi,
  input  logic                  I_gclk,
  input  logic [SCAN_N-1:0]     I_scan,
  input  logic                  I_clr_err,
  output logic                  O_word_vld,
  output logic [WORD_W-1:0]     O_word,
  output logic [CH_W-1:0]       O_ch_idx,
  output logic [SCAN_IDX_W-1:0] O_scan_idx,
  output logic                  O_line_done,
  output logic                  O_frame_done,
  output logic [GCNT_W-1:0]     O_gclk_cnt,
  output logic                  O_gclk_cnt_vld,
  output logic                  O_err_len,
  output logic                  O_err_ovf,
  output logic                  O_err_scan
);

  logic              le_data, le_rise, le_fall;
  logic              dclk_data, dclk_rise, dclk_fall;
  logic              sdi_s, sdi_rise, sdi_fall;
  logic              gclk_data, gclk_rise, gclk_fall;
  logic [SCAN_N-1:0] scan_s, scan_rise, scan_fall;

  led_edge_sync #(.Width(1)) u_sync_le (
    .clk_i  (I_clk),
    .rst_ni (I_rst_n),
    .d_i    (I_le),
    .data_o (le_data),
    .rise_o (le_rise),
    .fall_o (le_fall)
  );

  led_edge_sync #(.Width(1)) u_sync_dclk (
    .clk_i  (I_clk),
    .rst_ni (I_rst_n),
    .d_i    (I_dclk),
    .data_o (dclk_data),
    .rise_o (dclk_rise),
    .fall_o (dclk_fall)
  );

  // Same depth as DCLK so each bit is sampled at its own clock edge.
  led_edge_sync #(.Width(1)) u_sync_sdi (
    .clk_i  (I_clk),
    .rst_ni (I_rst_n),
    .d_i    (I_sdi),
    .data_o (sdi_s),
    .rise_o (sdi_rise),
    .fall_o (sdi_fall)
  );

  led_edge_sync #(.Width(1)) u_sync_gclk (
    .clk_i  (I_clk),
    .rst_ni (I_rst_n),
    .d_i    (I_gclk),
    .data_o (gclk_data),
    .rise_o (gclk_rise),
    .fall_o (gclk_fall)
  );

  led_edge_sync #(.Width(SCAN_N)) u_sync_scan (
    .clk_i  (I_clk),
    .rst_ni (I_rst_n),
    .d_i    (I_scan),
    .data_o (scan_s),
    .rise_o (scan_rise),
    .fall_o (scan_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{le_data, le_rise, dclk_data, dclk_fall, sdi_rise, sdi_fall,
                         gclk_data, gclk_fall};

  logic [WORD_W-1:0]     shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [SCAN_IDX_W-1:0] scan_idx_q;
  logic [GCNT_W-1:0]     gclk_cnt_q, gclk_cnt_d;

  logic                  word_vld_q, line_done_q, frame_done_q, gclk_vld_q;
  logic [WORD_W-1:0]     word_q;
  logic [CH_W-1:0]       ch_idx_q;
  logic [SCAN_IDX_W-1:0] scan_idx_out_q;
  logic [GCNT_W-1:0]     gclk_out_q;
  logic                  err_len_q, err_ovf_q, err_scan_q;

  scan_dec_t scan_dec;
  logic      scan_chg, scan_ok, scan_bad;
  logic      len_bad, line_full, accept, ovf, last_ch;

  always_comb begin
    scan_dec  = scan_decode(scan_s);
    scan_chg  = |(scan_rise | scan_fall);
    scan_ok   = scan_chg & scan_dec.valid;
    scan_bad  = scan_chg & ~scan_dec.valid;

    len_bad   = le_fall & (bit_cnt_q != BIT_FULL);
    line_full = (ch_cnt_q == CH_FULL);
    accept    = le_fall & ~len_bad & ~line_full;
    ovf       = le_fall & ~len_bad & line_full;
    last_ch   = (ch_cnt_q == CH_LAST);

    bit_cnt_d = bit_cnt_q;
    if (le_fall) begin
      bit_cnt_d = '0;
    end else if (dclk_rise && (bit_cnt_q != BIT_SAT)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // A scan change wins over an accepted word: the word keeps the old indices.
    ch_cnt_d = ch_cnt_q;
    if (scan_ok) begin
      ch_cnt_d = '0;
    end else if (accept) begin
      ch_cnt_d = ch_cnt_q + 1'b1;
    end

    gclk_cnt_d = gclk_cnt_q;
    if (scan_ok) begin
      gclk_cnt_d = GCNT_W'(gclk_rise);
    end else if (gclk_rise && (gclk_cnt_q != '1)) begin
      gclk_cnt_d = gclk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      ch_cnt_q       <= '0;
      scan_idx_q     <= '0;
      gclk_cnt_q     <= '0;
      word_vld_q     <= 1'b0;
      word_q         <= '0;
      ch_idx_q       <= '0;
      scan_idx_out_q <= '0;
      line_done_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      gclk_out_q     <= '0;
      gclk_vld_q     <= 1'b0;
      err_len_q      <= 1'b0;
      err_ovf_q      <= 1'b0;
      err_scan_q     <= 1'b0;
    end else begin
      if (dclk_rise) begin
        shift_q <= {shift_q[WORD_W-2:0], sdi_s};
      end
      bit_cnt_q  <= bit_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      gclk_cnt_q <= gclk_cnt_d;
      if (scan_ok) begin
        scan_idx_q <= scan_dec.idx;
        gclk_out_q <= gclk_cnt_q;
      end
      gclk_vld_q <= scan_ok;

      word_vld_q   <= accept;
      line_done_q  <= accept & last_ch;
      frame_done_q <= accept & last_ch & (scan_idx_q == SCAN_LAST);
      if (accept) begin
        word_q         <= shift_q;
        ch_idx_q       <= ch_cnt_q;
        scan_idx_out_q <= scan_idx_q;
      end

      // Setting has priority over a same-cycle clear.
      err_len_q  <= (err_len_q & ~I_clr_err) | len_bad;
      err_ovf_q  <= (err_ovf_q & ~I_clr_err) | ovf;
      err_scan_q <= (err_scan_q & ~I_clr_err) | scan_bad;
    end
  end

  assign O_word_vld     = word_vld_q;
  assign O_word         = word_q;
  assign O_ch_idx       = ch_idx_q;
  assign O_scan_idx     = scan_idx_out_q;
  assign O_line_done    = line_done_q;
  assign O_frame_done   = frame_done_q;
  assign O_gclk_cnt     = gclk_out_q;
  assign O_gclk_cnt_vld = gclk_vld_q;
  assign O_err_len      = err_len_q;
  assign O_err_ovf      = err_ovf_q;
  assign O_err_scan     = err_scan_q;

endmodule
